// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad entry stage: key index map, FSM state
// type and function-code width.
// Optional feature macro: KEYPAD_ENTRY_BIN_EN (adds the CONVERT state).
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int KEY_W   = 16;   // keys on the pad, one latched bit each
    localparam int IDX_W   = 4;    // encoded key index width
    localparam int FUNC_W  = 2;    // function key code width

    // Key indices; 0..9 are the digits themselves.
    localparam logic [IDX_W-1:0] KEY_ENTER = 4'd10;
    localparam logic [IDX_W-1:0] KEY_BACK  = 4'd11;
    localparam logic [IDX_W-1:0] KEY_CLEAR = 4'd12;
    localparam logic [IDX_W-1:0] KEY_F0    = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_ACK     = 3'd2,
        ST_RELEASE = 3'd3
`ifdef KEYPAD_ENTRY_BIN_EN
        ,
        ST_CONVERT = 3'd4
`endif
    } state_e;

endpackage

// File: rtl/keypad_prio_enc.sv
// -----------------------------------------------------------------------------
// keypad_prio_enc
// Combinational 16-to-4 encoder: reports the index of the lowest set bit.
// Ports:
//   data_i   key bits, bit i = key i
//   idx_o    index of the lowest set bit (0 when none set)
//   valid_o  at least one bit set
// -----------------------------------------------------------------------------
module keypad_prio_enc
    import keypad_pkg::*;
(
    input  logic [KEY_W-1:0] data_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |data_i;
        // Scan from the top down so the lowest set bit is written last and wins.
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (data_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// -----------------------------------------------------------------------------
// keypad_entry
// Consumer of the keyboard block: snapshots the latched key bits, decodes the
// lowest pressed key into a digit / edit command / function key, maintains a
// right-aligned BCD entry and publishes committed values with a valid pulse.
// After each key it asserts key_clear until the upstream latch reads empty,
// giving up after CLR_TIMEOUT cycles (minimum meaningful value is 2).
//
// Optional feature macro: KEYPAD_ENTRY_BIN_EN
//   Adds value_bin and a CONVERT state that turns the committed BCD value
//   into binary (one digit per cycle, MSB first) before value_valid fires.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   key_interrupt  pulse: new key latched upstream
//   key_data       latched key bits
//   key_clear      request upstream to clear latched keys
//   entry_bcd      digits typed so far, right-aligned
//   entry_len      number of digits in entry_bcd
//   value_valid    one-cycle pulse: committed value available
//   value_bcd      committed value, held until next commit
//   func_valid     one-cycle pulse: function key pressed
//   func_code      function key index 0..2, held
//   entry_err      one-cycle pulse: rejected key or clear timeout
//   busy           FSM not in IDLE
//   value_bin      binary committed value (feature only)
// -----------------------------------------------------------------------------
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int CLR_TIMEOUT = 1000
`ifdef KEYPAD_ENTRY_BIN_EN
    ,
    parameter int BIN_W       = 14
`endif
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         key_interrupt,
    input  logic [KEY_W-1:0]             key_data,
    output logic                         key_clear,
    output logic [4*DIGITS-1:0]          entry_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  entry_len,
    output logic                         value_valid,
    output logic [4*DIGITS-1:0]          value_bcd,
    output logic                         func_valid,
    output logic [FUNC_W-1:0]            func_code,
    output logic                         entry_err,
    output logic                         busy
`ifdef KEYPAD_ENTRY_BIN_EN
    ,
    output logic [BIN_W-1:0]             value_bin
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int LEN_W = $clog2(DIGITS + 1);
    localparam int CNT_W = $clog2(CLR_TIMEOUT + 1);

    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [KEY_W-1:0]    snap_q, snap_d;
    logic [BCD_W-1:0]    entry_bcd_q, entry_bcd_d;
    logic [LEN_W-1:0]    entry_len_q, entry_len_d;
    logic [BCD_W-1:0]    value_bcd_q, value_bcd_d;
    logic                value_valid_q, value_valid_d;
    logic                func_valid_q, func_valid_d;
    logic [FUNC_W-1:0]   func_code_q, func_code_d;
    logic                entry_err_q, entry_err_d;
    logic                key_clear_q, key_clear_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_W-1:0]    enc_idx;
    logic                enc_valid;

`ifdef KEYPAD_ENTRY_BIN_EN
    logic [BCD_W-1:0]    conv_sh_q, conv_sh_d;
    logic [LEN_W-1:0]    conv_idx_q, conv_idx_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [BIN_W-1:0]    value_bin_q, value_bin_d;
    logic [BCD_W-1:0]    conv_rot;
    logic [3:0]          conv_digit;
    logic [BIN_W-1:0]    acc_next;

    // The working copy is rotated left one digit per cycle, so after DIGITS
    // cycles it holds the original BCD value again and can be published as-is.
    assign conv_digit = conv_sh_q[BCD_W-1 -: 4];
    assign conv_rot   = (conv_sh_q << 4) | (conv_sh_q >> (BCD_W - 4));
    assign acc_next   = acc_q * BIN_W'(10) + BIN_W'(conv_digit);
`endif

    keypad_prio_enc u_prio_enc (
        .data_i  (snap_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        entry_bcd_d   = entry_bcd_q;
        entry_len_d   = entry_len_q;
        value_bcd_d   = value_bcd_q;
        value_valid_d = 1'b0;
        func_valid_d  = 1'b0;
        func_code_d   = func_code_q;
        entry_err_d   = 1'b0;
        key_clear_d   = key_clear_q;
        cnt_d         = cnt_q;
`ifdef KEYPAD_ENTRY_BIN_EN
        conv_sh_d     = conv_sh_q;
        conv_idx_d    = conv_idx_q;
        acc_d         = acc_q;
        value_bin_d   = value_bin_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (key_interrupt || (key_data != '0)) begin
                    snap_d  = key_data;
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                state_d     = ST_ACK;
                key_clear_d = 1'b1;
                cnt_d       = '0;
                // An empty snapshot (interrupt without data) takes no action.
                if (enc_valid) begin
                    if (enc_idx < KEY_ENTER) begin
                        if (entry_len_q < LEN_FULL) begin
                            entry_bcd_d = (entry_bcd_q << 4) | BCD_W'(enc_idx);
                            entry_len_d = entry_len_q + LEN_W'(1);
                        end else begin
                            entry_err_d = 1'b1;
                        end
                    end else if (enc_idx == KEY_ENTER) begin
                        if (entry_len_q != '0) begin
`ifdef KEYPAD_ENTRY_BIN_EN
                            conv_sh_d   = entry_bcd_q;
                            conv_idx_d  = '0;
                            acc_d       = '0;
                            state_d     = ST_CONVERT;
                            key_clear_d = 1'b0;
`else
                            value_bcd_d   = entry_bcd_q;
                            value_valid_d = 1'b1;
`endif
                            entry_bcd_d = '0;
                            entry_len_d = '0;
                        end else begin
                            entry_err_d = 1'b1;
                        end
                    end else if (enc_idx == KEY_BACK) begin
                        if (entry_len_q != '0) begin
                            entry_bcd_d = entry_bcd_q >> 4;
                            entry_len_d = entry_len_q - LEN_W'(1);
                        end
                    end else if (enc_idx == KEY_CLEAR) begin
                        entry_bcd_d = '0;
                        entry_len_d = '0;
                    end else begin
                        func_code_d  = FUNC_W'(enc_idx - KEY_F0);
                        func_valid_d = 1'b1;
                    end
                end
            end

`ifdef KEYPAD_ENTRY_BIN_EN
            ST_CONVERT: begin
                conv_sh_d  = conv_rot;
                acc_d      = acc_next;
                conv_idx_d = conv_idx_q + LEN_W'(1);
                if (conv_idx_q == LEN_W'(DIGITS - 1)) begin
                    value_bcd_d   = conv_rot;
                    value_bin_d   = acc_next;
                    value_valid_d = 1'b1;
                    state_d       = ST_ACK;
                    key_clear_d   = 1'b1;
                    cnt_d         = '0;
                end
            end
`endif

            ST_ACK: begin
                // The ACK cycle is the first cycle of key_clear; count it.
                cnt_d   = CNT_W'(1);
                state_d = ST_RELEASE;
            end

            ST_RELEASE: begin
                if (key_data == '0) begin
                    key_clear_d = 1'b0;
                    state_d     = ST_IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    entry_err_d = 1'b1;
                    key_clear_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                key_clear_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            snap_q        <= '0;
            entry_bcd_q   <= '0;
            entry_len_q   <= '0;
            value_bcd_q   <= '0;
            value_valid_q <= 1'b0;
            func_valid_q  <= 1'b0;
            func_code_q   <= '0;
            entry_err_q   <= 1'b0;
            key_clear_q   <= 1'b0;
            cnt_q         <= '0;
`ifdef KEYPAD_ENTRY_BIN_EN
            conv_sh_q     <= '0;
            conv_idx_q    <= '0;
            acc_q         <= '0;
            value_bin_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            entry_bcd_q   <= entry_bcd_d;
            entry_len_q   <= entry_len_d;
            value_bcd_q   <= value_bcd_d;
            value_valid_q <= value_valid_d;
            func_valid_q  <= func_valid_d;
            func_code_q   <= func_code_d;
            entry_err_q   <= entry_err_d;
            key_clear_q   <= key_clear_d;
            cnt_q         <= cnt_d;
`ifdef KEYPAD_ENTRY_BIN_EN
            conv_sh_q     <= conv_sh_d;
            conv_idx_q    <= conv_idx_d;
            acc_q         <= acc_d;
            value_bin_q   <= value_bin_d;
`endif
        end
    end

    assign key_clear   = key_clear_q;
    assign entry_bcd   = entry_bcd_q;
    assign entry_len   = entry_len_q;
    assign value_valid = value_valid_q;
    assign value_bcd   = value_bcd_q;
    assign func_valid  = func_valid_q;
    assign func_code   = func_code_q;
    assign entry_err   = entry_err_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef KEYPAD_ENTRY_BIN_EN
    assign value_bin   = value_bin_q;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry
// Directed and random key sequences for keypad_entry, checked against a
// digit-queue model of the entry, the committed value and the pulses per key.
// -----------------------------------------------------------------------------
module tb_keypad_entry;

    localparam int DIGITS = 4;
    localparam int TO     = 24;

    logic        clk = 1'b0;
    logic        rstn;
    logic        key_interrupt;
    logic [15:0] key_data;
    logic        key_clear;
    logic [15:0] entry_bcd;
    logic [2:0]  entry_len;
    logic        value_valid;
    logic [15:0] value_bcd;
    logic        func_valid;
    logic [1:0]  func_code;
    logic        entry_err;
    logic        busy;
`ifdef KEYPAD_ENTRY_BIN_EN
    logic [13:0] value_bin;
`endif

    always #5 clk = ~clk;

    keypad_entry #(
        .DIGITS      (DIGITS),
        .CLR_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .key_interrupt (key_interrupt),
        .key_data      (key_data),
        .key_clear     (key_clear),
        .entry_bcd     (entry_bcd),
        .entry_len     (entry_len),
        .value_valid   (value_valid),
        .value_bcd     (value_bcd),
        .func_valid    (func_valid),
        .func_code     (func_code),
        .entry_err     (entry_err),
        .busy          (busy)
`ifdef KEYPAD_ENTRY_BIN_EN
        ,
        .value_bin     (value_bin)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: entry as a list of decimal digits, oldest first.
    int     ent[$];
    longint m_vbcd = 0;
    longint m_vdec = 0;
    int     m_func = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint ent_bcd();
        longint r = 0;
        foreach (ent[i]) r = r * 16 + ent[i];
        return r;
    endfunction

    function automatic longint ent_dec();
        longint r = 0;
        foreach (ent[i]) r = r * 10 + ent[i];
        return r;
    endfunction

    task automatic model_reset();
        ent.delete();
        m_vbcd = 0;
        m_vdec = 0;
        m_func = 0;
    endtask

    task automatic model_key(input logic [15:0] bits, output int evv, output int efv, output int eee);
        int k = -1;
        evv = 0; efv = 0; eee = 0;
        for (int b = 0; b < 16; b++) begin
            if (bits[b] && k < 0) k = b;
        end
        if (k < 0) return;
        if (k < 10) begin
            if (ent.size() < DIGITS) ent.push_back(k);
            else eee = 1;
        end else if (k == 10) begin
            if (ent.size() > 0) begin
                m_vbcd = ent_bcd();
                m_vdec = ent_dec();
                evv = 1;
                ent.delete();
            end else begin
                eee = 1;
            end
        end else if (k == 11) begin
            if (ent.size() > 0) void'(ent.pop_back());
        end else if (k == 12) begin
            ent.delete();
        end else begin
            m_func = k - 13;
            efv = 1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".entry_bcd"}, 64'(entry_bcd), 64'(ent_bcd()));
        check({tag, ".entry_len"}, 64'(entry_len), 64'(ent.size()));
        check({tag, ".value_bcd"}, 64'(value_bcd), 64'(m_vbcd));
        check({tag, ".func_code"}, 64'(func_code), 64'(m_func));
`ifdef KEYPAD_ENTRY_BIN_EN
        check({tag, ".value_bin"}, 64'(value_bin), 64'(m_vdec));
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".key_clear"},   64'(key_clear),   64'd0);
        check({tag, ".entry_bcd"},   64'(entry_bcd),   64'd0);
        check({tag, ".entry_len"},   64'(entry_len),   64'd0);
        check({tag, ".value_valid"}, 64'(value_valid), 64'd0);
        check({tag, ".value_bcd"},   64'(value_bcd),   64'd0);
        check({tag, ".func_valid"},  64'(func_valid),  64'd0);
        check({tag, ".func_code"},   64'(func_code),   64'd0);
        check({tag, ".entry_err"},   64'(entry_err),   64'd0);
        check({tag, ".busy"},        64'(busy),        64'd0);
`ifdef KEYPAD_ENTRY_BIN_EN
        check({tag, ".value_bin"},   64'(value_bin),   64'd0);
`endif
    endtask

    // One key: latch bits for `hold` cycles, then release; wait for the FSM
    // to return to IDLE and compare pulses and state against the model.
    task automatic press(input string tag, input logic [15:0] bits, input int hold, input bit irq);
        int  evv, efv, eee;
        int  vv_c = 0, fv_c = 0, ee_c = 0, clr_c = 0, ovl = 0;
        int  i = 0;
        bit  seen = 0, done = 0;
        model_key(bits, evv, efv, eee);
        @(posedge clk); #1;
        key_data = bits;
        key_interrupt = irq;
        while (i < 200) begin
            @(negedge clk);
            vv_c  += int'(value_valid);
            fv_c  += int'(func_valid);
            ee_c  += int'(entry_err);
            clr_c += int'(key_clear);
            if (int'(value_valid) + int'(func_valid) + int'(entry_err) > 1) ovl++;
            if (busy) seen = 1;
            if (seen && !busy && i >= hold) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
            key_interrupt = 1'b0;
            i++;
            if (i >= hold) key_data = '0;
        end
        key_data = '0;
        key_interrupt = 1'b0;
        check({tag, ".done"},        64'(done),  64'd1);
        check({tag, ".value_valid"}, 64'(vv_c),  64'(evv));
        check({tag, ".func_valid"},  64'(fv_c),  64'(efv));
        check({tag, ".entry_err"},   64'(ee_c),  64'(eee));
        check({tag, ".overlap"},     64'(ovl),   64'd0);
        check({tag, ".clr_range"},   64'((clr_c >= 2) && (clr_c <= 7)), 64'd1);
        check({tag, ".key_clear"},   64'(key_clear), 64'd0);
        check_state(tag);
        $display("key %s bits=%04h hold=%0d clr=%0d vv=%0d fv=%0d err=%0d len=%0d entry=%04h value=%04h",
                 tag, bits, hold, clr_c, vv_c, fv_c, ee_c, entry_len, entry_bcd, value_bcd);
    endtask

    initial begin
        int n;
        int run;
        int pcount;
        logic [15:0] bits;
        int k;

        rstn = 1'b0;
        key_data = '0;
        key_interrupt = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;

        // 1,2,3 ENTER
        press("d1", 16'h0002, 5, 1'b1);
        press("d2", 16'h0004, 5, 1'b1);
        press("d3", 16'h0008, 5, 1'b1);
        press("enter", 16'h0400, 5, 1'b1);
        check("commit.value_bcd", 64'(value_bcd), 64'h0123);
        check("commit.entry_len", 64'(entry_len), 64'd0);
`ifdef KEYPAD_ENTRY_BIN_EN
        check("commit.value_bin", 64'(value_bin), 64'd123);
`endif

        // Overflow then BACK
        press("d9", 16'h0200, 2, 1'b1);
        press("d8", 16'h0100, 2, 1'b1);
        press("d7", 16'h0080, 2, 1'b1);
        press("d6", 16'h0040, 2, 1'b1);
        press("d5_full", 16'h0020, 2, 1'b1);
        check("full.entry_bcd", 64'(entry_bcd), 64'h9876);
        press("back", 16'h0800, 2, 1'b1);
        check("back.entry_bcd", 64'(entry_bcd), 64'h0987);
        check("back.entry_len", 64'(entry_len), 64'd3);

        // Empty ENTER / BACK
        press("clear", 16'h1000, 1, 1'b1);
        press("enter_empty", 16'h0400, 1, 1'b1);
        press("back_empty", 16'h0800, 1, 1'b1);

        // Multi-bit: lowest wins; then function 2
        press("multi", 16'h2004, 3, 1'b1);
        check("multi.entry_bcd", 64'(entry_bcd), 64'h0002);
        press("f2", 16'h8000, 3, 1'b1);
        check("f2.func_code", 64'(func_code), 64'd2);

        // Interrupt without data
        press("irq_only", 16'h0000, 1, 1'b1);

        // Stuck key: timeout, then re-capture
        press("clear2", 16'h1000, 1, 1'b1);
        @(posedge clk); #1;
        key_data = 16'h0001;
        key_interrupt = 1'b1;
        @(posedge clk); #1;
        key_interrupt = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!key_clear && n < 20);
        check("stuck.clear_seen", 64'(key_clear), 64'd1);
        run = 0;
        while (key_clear && run < 4 * TO) begin
            run++;
            @(negedge clk);
        end
        ent.push_back(0);
        check("stuck.clear_cycles", 64'(run), 64'(TO));
        check("stuck.entry_err", 64'(entry_err), 64'd1);
        check("stuck.idle", 64'(busy), 64'd0);
        check("stuck.entry_len1", 64'(entry_len), 64'(ent.size()));
        @(negedge clk);
        check("stuck.recapture", 64'(busy), 64'd1);
        @(posedge clk); #1;
        key_data = '0;
        ent.push_back(0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        check("stuck.release_idle", 64'(busy), 64'd0);
        check_state("stuck");
        $display("key stuck bits=0001 clear_cycles=%0d len=%0d", run, entry_len);

        // Random keys
        for (int r = 0; r < 80; r++) begin
            if ($urandom_range(0, 3) != 0) k = $urandom_range(0, 9);
            else k = $urandom_range(10, 15);
            bits = 16'(1 << k);
            if ($urandom_range(0, 3) == 0) bits = bits | 16'($urandom());
            if ($urandom_range(0, 11) == 0) bits = '0;
            press("rand", bits, $urandom_range(1, 6), 1'b1);
        end

        // Reset during RELEASE
        press("pre_rst", 16'h0080, 2, 1'b1);
        @(posedge clk); #1;
        key_data = 16'h0040;
        key_interrupt = 1'b1;
        @(posedge clk); #1;
        key_interrupt = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!key_clear && n < 20);
        @(negedge clk);
        @(negedge clk);
        check("rst_rel.in_release", 64'(key_clear), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all_zero("rst_rel");
        key_data = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
        pcount = 0;
        repeat (10) begin
            @(negedge clk);
            pcount += int'(value_valid) + int'(func_valid) + int'(entry_err) + int'(busy);
        end
        check("rst_rel.no_pulse", 64'(pcount), 64'd0);
        check_state("rst_rel");
        $display("reset during RELEASE activity=%0d", pcount);

`ifdef KEYPAD_ENTRY_BIN_EN
        // Reset during CONVERT
        press("pre_conv", 16'h0010, 1, 1'b1);
        @(posedge clk); #1;
        key_data = 16'h0400;
        key_interrupt = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        key_interrupt = 1'b0;
        key_data = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_conv.busy", 64'(busy), 64'd1);
        check("rst_conv.no_clear", 64'(key_clear), 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all_zero("rst_conv");
        @(posedge clk); #1;
        rstn = 1'b1;
        pcount = 0;
        repeat (10) begin
            @(negedge clk);
            pcount += int'(value_valid) + int'(func_valid) + int'(entry_err) + int'(busy);
        end
        check("rst_conv.no_pulse", 64'(pcount), 64'd0);
        check_state("rst_conv");
        $display("reset during CONVERT activity=%0d", pcount);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
